// File: rtl/imem_loader.sv
// imem_loader: writable 64-word instruction memory for the single-cycle LEGv8
// core, filled from a little-endian byte stream over valid/ready.
// The core reads through a combinational port (addr -> q). While a load runs,
// cpu_hold keeps the core stalled.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When it is defined, one
// XOR checksum byte follows the data. A mismatch raises err.
module imem_loader #(
    parameter int N     = 32,
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_start,
    input  logic [6:0]   load_len,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    input  logic [5:0]   addr,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         done,
    output logic         cpu_hold,
    output logic         err
);

    localparam int NB = N / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
    localparam logic [6:0]    MAX_WORDS = 7'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RECV = 2'd1, S_FIN = 2'd2, S_CHK = 2'd3} state_t;
    // After the last data word, the loader still needs the checksum byte.
    localparam state_t S_AFTER = S_CHK;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RECV = 2'd1, S_FIN = 2'd2} state_t;
    localparam state_t S_AFTER = S_FIN;
`endif

    state_t          state_q, state_d;
    logic [5:0]      wr_ptr_q, wr_ptr_d;
    logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [6:0]      words_left_q, words_left_d;
    logic [N-1:0]    word_buf_q, word_buf_d;
    logic [N-1:0]    word_asm;
    logic            mem_we;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic            err_q, err_d;
    logic [7:0]      xor_q, xor_d;
`endif

    // Program storage. The contents start at zero and survive reset.
    logic [N-1:0] mem_q [DEPTH] = '{default: '0};

    // Build the word buffer with the incoming byte placed in its lane (little-endian).
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
        assign word_asm[8*gi +: 8] = (byte_cnt_q == BW'(gi)) ? in_data : word_buf_q[8*gi +: 8];
    end

    // The RAM write happens on the edge that accepts the final byte of a word.
    assign mem_we = (state_q == S_RECV) && in_valid && (byte_cnt_q == LAST_BYTE);

    // RAM write port. The read port is combinational, so a colliding read
    // returns the old word until the next cycle.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= word_asm;
        end
    end

    assign q = mem_q[addr];

    // Next-state logic and state-decoded outputs of the loader FSM.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        byte_cnt_d   = byte_cnt_q;
        words_left_d = words_left_q;
        word_buf_d   = word_buf_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        err_d        = err_q;
        xor_d        = xor_q;
`endif
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        cpu_hold     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    wr_ptr_d   = '0;
                    byte_cnt_d = '0;
                    word_buf_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    err_d      = 1'b0;
                    xor_d      = 8'h00;
`endif
                    if (load_len == 7'd0) begin
                        words_left_d = 7'd0;
                        state_d      = S_AFTER;
                    end else begin
                        // Clamp oversize requests so the pointer never runs past entry 63.
                        words_left_d = (load_len > MAX_WORDS) ? MAX_WORDS : load_len;
                        state_d      = S_RECV;
                    end
                end
            end

            S_RECV: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (in_valid) begin
                    word_buf_d = word_asm;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d      = xor_q ^ in_data;
`endif
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d   = '0;
                        wr_ptr_d     = wr_ptr_q + 6'd1;
                        words_left_d = words_left_q - 7'd1;
                        if (words_left_q == 7'd1) begin
                            state_d = S_AFTER;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BW'(1);
                    end
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (in_valid) begin
                    err_d   = (in_data != xor_q);
                    state_d = S_FIN;
                end
            end
`endif

            S_FIN: begin
                done     = 1'b1;
                cpu_hold = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Loader state registers. Reset abandons any partial word immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            byte_cnt_q   <= '0;
            words_left_q <= '0;
            word_buf_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            byte_cnt_q   <= byte_cnt_d;
            words_left_q <= words_left_d;
            word_buf_q   <= word_buf_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum accumulator and the sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
            xor_q <= 8'h00;
        end else begin
            err_q <= err_d;
            xor_q <= xor_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. Stimulus tasks push expected done events and
// expected read data into queues. A monitor then pops from those queues and
// compares whenever the DUT pulses done or a read is presented.
module tb_imem_loader;

    localparam int N = 32;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CHK_CYC = 1;
`else
    localparam int CHK_CYC = 0;
`endif

    logic         clk        = 1'b0;
    logic         reset      = 1'b1;
    logic         load_start = 1'b0;
    logic [6:0]   load_len   = 7'd0;
    logic         in_valid   = 1'b0;
    logic [7:0]   in_data    = 8'h00;
    logic         in_ready;
    logic [5:0]   addr       = 6'd0;
    logic [N-1:0] q;
    logic         busy;
    logic         done;
    logic         cpu_hold;
    logic         err;

    imem_loader #(.N(N), .DEPTH(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_len   (load_len),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .addr       (addr),
        .q          (q),
        .busy       (busy),
        .done       (done),
        .cpu_hold   (cpu_hold),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   busy_cycles;
        logic err;
    } done_exp_t;

    done_exp_t    done_q[$];
    logic [N-1:0] rd_q[$];
    int           errors  = 0;
    int           checks  = 0;
    logic         rd_en   = 1'b0;
    logic [7:0]   run_xor = 8'h00;
    int           busy_cnt  = 0;
    logic         prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scores done pulses and read transactions against the queues.
    always @(negedge clk) begin : monitor
        done_exp_t    e;
        logic [N-1:0] exp_q;
        if (!reset) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) check("hold_release", {63'd0, cpu_hold}, 64'd0);
            if (busy) busy_cnt++;
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 with no load pending, expected done=0");
                end else begin
                    e = done_q.pop_front();
                    check("busy_cycles", 64'(busy_cnt), 64'(e.busy_cycles));
                    check("err_at_done", {63'd0, err}, {63'd0, e.err});
                    check("hold_at_done", {63'd0, cpu_hold}, 64'd1);
                    $display("load done: busy_cycles=%0d err=%0b", busy_cnt, err);
                end
                busy_cnt = 0;
            end
            prev_done = done;
        end
        if (rd_en) begin
            exp_q = rd_q.pop_front();
            check("rd_data", 64'(q), 64'(exp_q));
            $display("read: addr=%0d q=%08h exp=%08h", addr, q, exp_q);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
        end else begin
            run_xor ^= b;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic begin_load(input logic [6:0] len);
        load_start = 1'b1;
        load_len   = len;
        run_xor    = 8'h00;
        tick();
        load_start = 1'b0;
    endtask

    task automatic start_load(input logic [6:0] len, input int busy_exp, input logic err_exp);
        done_exp_t e;
        e.busy_cycles = busy_exp;
        e.err         = err_exp;
        done_q.push_back(e);
        begin_load(len);
    endtask

    task automatic finish_chk(input logic [7:0] b);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(b);
`else
        run_xor = run_xor ^ b ^ b;
`endif
    endtask

    task automatic read_chk(input logic [5:0] a, input logic [N-1:0] exp);
        addr = a;
        rd_q.push_back(exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_busy",     {63'd0, busy},     64'd0);
        check("rst_done",     {63'd0, done},     64'd0);
        check("rst_cpu_hold", {63'd0, cpu_hold}, 64'd0);
        check("rst_err",      {63'd0, err},      64'd0);
        tick();
        reset = 1'b1;
        tick();

        // 3-word load that stalls for 5 cycles in the middle of word 1.
        start_load(7'd3, 17 + CHK_CYC, 1'b0);
        send_word(32'h8b1e03c5);
        send_byte(8'ha5);
        send_byte(8'h00);
        for (int k = 0; k < 5; k++) begin
            check("gap_in_ready", {63'd0, in_ready}, 64'd1);
            if (k < 3) read_chk(6'd1, 32'h0);
            else       read_chk(6'd0, 32'h8b1e03c5);
        end
        send_byte(8'h04);
        send_byte(8'h8b);
        send_word(32'hcb020042);
        finish_chk(run_xor);
        tick();
        read_chk(6'd0, 32'h8b1e03c5);
        read_chk(6'd1, 32'h8b0400a5);
        read_chk(6'd2, 32'hcb020042);
        read_chk(6'd3, 32'h0);

        // The same load again with no gaps: 12 busy cycles.
        start_load(7'd3, 12 + CHK_CYC, 1'b0);
        send_word(32'h8b1e03c5);
        send_word(32'h8b0400a5);
        send_word(32'hcb020042);
        finish_chk(run_xor);
        tick();
        read_chk(6'd0, 32'h8b1e03c5);
        read_chk(6'd1, 32'h8b0400a5);
        read_chk(6'd2, 32'hcb020042);
        read_chk(6'd3, 32'h0);

        // Full 64-word load where word i = i.
        start_load(7'd64, 256 + CHK_CYC, 1'b0);
        for (int i = 0; i < 64; i++) send_word(32'(i));
        finish_chk(run_xor);
        tick();
        read_chk(6'd0, 32'd0);
        read_chk(6'd31, 32'd31);
        read_chk(6'd63, 32'd63);

        // A 1-word load overwrites only entry 0.
        start_load(7'd1, 4 + CHK_CYC, 1'b0);
        send_word(32'hb400001f);
        finish_chk(run_xor);
        tick();
        read_chk(6'd0, 32'hb400001f);
        read_chk(6'd1, 32'd1);
        read_chk(6'd63, 32'd63);

        // Zero-length load: done follows immediately and nothing is written.
        start_load(7'd0, CHK_CYC, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        finish_chk(8'h00);
`else
        @(negedge clk);
        check("len0_done", {63'd0, done}, 64'd1);
        #4;
`endif
        tick();
        read_chk(6'd0, 32'hb400001f);

        // An oversize request is clamped to 64 words.
        start_load(7'd100, 256 + CHK_CYC, 1'b0);
        for (int i = 0; i < 64; i++) send_word(32'(i + 100));
        finish_chk(run_xor);
        tick();
        check("len100_idle_ready", {63'd0, in_ready}, 64'd0);
        read_chk(6'd0, 32'd100);
        read_chk(6'd63, 32'd163);

        // Reset after two bytes of word 1 in a 3-word load.
        begin_load(7'd3);
        send_word(32'h11223344);
        send_byte(8'haa);
        send_byte(8'hbb);
        reset = 1'b0;
        #1;
        check("midrst_busy",     {63'd0, busy},     64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        check("midrst_done",     {63'd0, done},     64'd0);
        check("midrst_cpu_hold", {63'd0, cpu_hold}, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        read_chk(6'd0, 32'h11223344);
        read_chk(6'd1, 32'd101);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum of 00 00 08 8b is 0x83.
        start_load(7'd1, 5, 1'b0);
        send_word(32'h8b080000);
        finish_chk(8'h83);
        tick();
        check("chk_good_err", {63'd0, err}, 64'd0);
        read_chk(6'd0, 32'h8b080000);

        start_load(7'd1, 5, 1'b1);
        send_word(32'h8b080000);
        finish_chk(8'h00);
        tick();
        check("chk_bad_err_hold", {63'd0, err}, 64'd1);
        read_chk(6'd0, 32'h8b080000);
`endif

        repeat (3) tick();
        check("done_pending", 64'(done_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
